spi_rom_read_arbiter: RTL

- Shares one SPI flash ROM between NUM_REQ requesters.
- Each requester asks for a burst read of N bits from a 24-bit address. The block arbitrates round-robin, then sequences CMD, ADDR, optional DUMMY and DATA phases on the SPI pins.
- Read bits are returned serially, tagged with the owner index.
- Sits between display/fetch clients (e.g. line buffer fillers) and the top-level SPI pins. It replaces ad-hoc hpos-driven sequencing.

---
 rtl/spi_rom_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/spi_rom_read_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/spi_rom_pkg.sv
// spi_rom_pkg: SPI ROM command codes, phase lengths and sequencer state encoding
package spi_rom_pkg;
    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam int SPI_CMD_LEN   = 8;
    localparam int SPI_ADDR_LEN  = 24;
    localparam int SPI_DUMMY_LEN = 8;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DUMMY = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after last_owner
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int OW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OW-1:0]      last_owner,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [OW-1:0]      idx
);
    logic [OW:0] c;
    logic        found;

    // scan cyclically starting one past last_owner, last_owner itself checked last
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = {1'b0, last_owner} + (OW+1)'(k);
            if (c >= (OW+1)'(NUM_REQ)) c = c - (OW+1)'(NUM_REQ);
            if (enable && !found && req[c[OW-1:0]]) begin
                found            = 1'b1;
                gnt[c[OW-1:0]]   = 1'b1;
                idx              = c[OW-1:0];
            end
        end
    end
endmodule

// File: rtl/spi_rom_read_arbiter.sv
// spi_rom_read_arbiter: shares one SPI ROM among requesters; SPI_FAST_READ_EN selects FAST READ (0x0B) with a dummy phase
module spi_rom_read_arbiter
    import spi_rom_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int LEN_W      = 8,
    parameter int GAP_CYCLES = 2,
    localparam int OW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*24-1:0]    req_addr,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     rd_valid,
    output logic                     rd_bit,
    output logic [OW-1:0]            rd_owner,
    output logic                     rd_last,
    output logic                     done,
    output logic                     spi_cs,
    output logic                     spi_sclk,
    output logic                     spi_mosi,
    input  logic                     spi_miso
);
    localparam int CW = LEN_W + 1;
`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] CMD          = CMD_FAST_READ;
    localparam logic [2:0] ST_POST_ADDR = ST_DUMMY;
`else
    localparam logic [7:0] CMD          = CMD_READ;
    localparam logic [2:0] ST_POST_ADDR = ST_DATA;
`endif

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [31:0]        sh_q, sh_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [OW-1:0]      owner_q, owner_d, last_owner_q, last_owner_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d, cs_q, cs_d, mosi_q, mosi_d;
    logic               rd_valid_q, rd_valid_d, rd_bit_q, rd_bit_d, rd_last_q, rd_last_d;
    logic               cap_q;
    logic [NUM_REQ-1:0] a_gnt;
    logic [OW-1:0]      a_idx;
    logic [CW-1:0]      lenx;
    logic               data_end;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req),
        .last_owner (last_owner_q),
        .enable     (state_q == ST_IDLE),
        .gnt        (a_gnt),
        .idx        (a_idx)
    );

    assign lenx     = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};
    assign data_end = cnt_q == lenx - 1'b1;
    assign spi_sclk = ~clk;
    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign spi_cs   = cs_q;
    assign spi_mosi = mosi_q;
    assign rd_valid = rd_valid_q;
    assign rd_bit   = rd_bit_q;
    assign rd_last  = rd_last_q;
    assign done     = rd_last_q;
    assign rd_owner = owner_q;

    // ROM data is sampled on the spi_sclk rising edge, i.e. mid-cycle on clk
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) cap_q <= 1'b0;
        else        cap_q <= spi_miso;
    end

    // phase sequencer: grant, shift out command+address, count data bits, enforce gap
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        sh_d         = sh_q << 1;
        mosi_d       = sh_q[31];
        len_d        = len_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        gnt_d        = '0;
        busy_d       = busy_q;
        cs_d         = cs_q;
        rd_valid_d   = state_q == ST_DATA;
        rd_bit_d     = (state_q == ST_DATA) ? cap_q : rd_bit_q;
        rd_last_d    = (state_q == ST_DATA) && data_end;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                mosi_d = 1'b0;
                if (|a_gnt) begin
                    gnt_d        = a_gnt;
                    owner_d      = a_idx;
                    last_owner_d = a_idx;
                    len_d        = req_len[int'(a_idx)*LEN_W +: LEN_W];
                    sh_d         = {CMD[6:0], req_addr[int'(a_idx)*24 +: 24], 1'b0};
                    mosi_d       = CMD[7];
                    cs_d         = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cnt_q == CW'(SPI_CMD_LEN-1)) begin
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (cnt_q == CW'(SPI_ADDR_LEN-1)) begin
                    cnt_d   = '0;
                    mosi_d  = 1'b0;
                    state_d = ST_POST_ADDR;
                end
            end
            ST_DUMMY: begin
                mosi_d = 1'b0;
                if (cnt_q == CW'(SPI_DUMMY_LEN-1)) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                mosi_d = 1'b0;
                if (data_end) begin
                    cnt_d   = '0;
                    cs_d    = 1'b0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                mosi_d = 1'b0;
                if (cnt_q == CW'(GAP_CYCLES-1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                mosi_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // sequencer state; reset drops the bus immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sh_q         <= '0;
            len_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= OW'(NUM_REQ-1);
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            cs_q         <= 1'b0;
            mosi_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_bit_q     <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            len_q        <= len_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            cs_q         <= cs_d;
            mosi_q       <= mosi_d;
            rd_valid_q   <= rd_valid_d;
            rd_bit_q     <= rd_bit_d;
            rd_last_q    <= rd_last_d;
        end
    end
endmodule
